// File: rtl/melody_if.sv
`timescale 1ns/1ps
// melody_if: control, song-write and playback-status bundle of melody_seq.
//   master: start, stop, loop_en, wr_en, wr_addr, wr_code, wr_beats -> design
//   slave : speaker, busy, done, note_idx, cur_code                  -> controller
interface melody_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [4:0]        wr_code;
  logic [3:0]        wr_beats;
  logic              speaker;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] note_idx;
  logic [4:0]        cur_code;

  modport master (
    output start, stop, loop_en, wr_en, wr_addr, wr_code, wr_beats,
    input  speaker, busy, done, note_idx, cur_code
  );

  modport slave (
    input  start, stop, loop_en, wr_en, wr_addr, wr_code, wr_beats,
    output speaker, busy, done, note_idx, cur_code
  );
endinterface

// File: rtl/melody_seq.sv
`timescale 1ns/1ps
// melody_seq: song RAM + note sequencer + square-wave tone divider.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   bus      melody_if.slave: start/stop/loop_en control, song RAM write
//            port (wr_en/wr_addr/wr_code/wr_beats), and registered outputs
//            speaker, busy, done, note_idx, cur_code.
module melody_seq #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 500000,
  parameter int unsigned DIV_SHIFT   = 0,
  parameter int unsigned CNT_W       = 19
) (
  input  logic clk,
  input  logic rst,
  melody_if.slave bus
);

  localparam int unsigned SONG_LEN = 2 ** ADDR_W;
  // Sized for the longest note (15 beats) so the product never wraps.
  localparam int unsigned DUR_W    = $clog2(15 * BEAT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, NOTE, GAP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] note_idx, idx_n;
  logic [4:0]        cur_code, code_n;
  logic [DUR_W-1:0]  dur, dur_n;
  logic [CNT_W-1:0]  cnt, cnt_n, half;
  logic              speaker, spk_n;
  logic              done, done_n;
  logic              busy, busy_n;
  logic              end_hit, end_m0;
  logic [4:0]        rd_code;
  logic [3:0]        rd_beats;
  logic [8:0]        song_mem [SONG_LEN];

  // Half period of a note code; 0 marks a rest (including undefined codes).
  function automatic logic [CNT_W-1:0] half_of(input logic [4:0] code);
    logic [31:0] p;
    case (code)
      5'd1:  p = 32'd95547;
      5'd2:  p = 32'd85135;
      5'd3:  p = 32'd75838;
      5'd4:  p = 32'd71582;
      5'd5:  p = 32'd63776;
      5'd6:  p = 32'd56818;
      5'd7:  p = 32'd50618;
      5'd11: p = 32'd47778;
      5'd12: p = 32'd42564;
      5'd13: p = 32'd37922;
      5'd14: p = 32'd35794;
      5'd15: p = 32'd31888;
      5'd16: p = 32'd28409;
      5'd17: p = 32'd25310;
      5'd21: p = 32'd23889;
      5'd22: p = 32'd21286;
      5'd23: p = 32'd18961;
      5'd24: p = 32'd16892;
      5'd25: p = 32'd15944;
      5'd26: p = 32'd14205;
      5'd27: p = 32'd12655;
      default: p = 32'd0;
    endcase
    return CNT_W'((p >> DIV_SHIFT) >> 1);
  endfunction

  // Song RAM: writable at any time, never cleared by reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) song_mem[bus.wr_addr] <= {bus.wr_code, bus.wr_beats};
  end

  assign {rd_code, rd_beats} = song_mem[note_idx];
  assign half = half_of(cur_code);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      note_idx <= '0;
      cur_code <= '0;
      dur      <= '0;
      cnt      <= '0;
      speaker  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      note_idx <= idx_n;
      cur_code <= code_n;
      dur      <= dur_n;
      cnt      <= cnt_n;
      speaker  <= spk_n;
      done     <= done_n;
      busy     <= busy_n;
    end
  end

  // Sequencer next state, tone divider and registered-output next values.
  always_comb begin
    state_n = state;
    idx_n   = note_idx;
    code_n  = cur_code;
    dur_n   = dur;
    cnt_n   = '0;
    spk_n   = 1'b0;
    done_n  = 1'b0;
    end_hit = 1'b0;
    end_m0  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          idx_n   = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (rd_beats == 4'd0) begin
          end_hit = 1'b1;
          end_m0  = (note_idx == '0);
        end else begin
          code_n  = rd_code;
          dur_n   = DUR_W'(rd_beats) * DUR_W'(BEAT_CYCLES) - DUR_W'(GAP_CYCLES);
          state_n = NOTE;
        end
      end
      NOTE: begin
        if (half != '0) begin
          if (cnt == half - CNT_W'(1)) begin
            cnt_n = '0;
            spk_n = ~speaker;
          end else begin
            cnt_n = cnt + CNT_W'(1);
            spk_n = speaker;
          end
        end
        if (dur <= DUR_W'(1)) begin
          state_n = GAP;
          dur_n   = DUR_W'(GAP_CYCLES);
          cnt_n   = '0;
          spk_n   = 1'b0;
        end else begin
          dur_n = dur - DUR_W'(1);
        end
      end
      GAP: begin
        if (dur <= DUR_W'(1)) begin
          if (note_idx == {ADDR_W{1'b1}}) begin
            end_hit = 1'b1;
          end else begin
            idx_n   = note_idx + ADDR_W'(1);
            state_n = LOAD;
          end
        end else begin
          dur_n = dur - DUR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // An end marker at entry 0 always ends playback so an empty song cannot spin.
    if (end_hit) begin
      if (bus.loop_en && !end_m0) begin
        idx_n   = '0;
        state_n = LOAD;
      end else begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end

    // Stop overrides everything, including a simultaneous start; position is held.
    if (bus.stop) begin
      state_n = IDLE;
      idx_n   = note_idx;
      code_n  = cur_code;
      cnt_n   = '0;
      spk_n   = 1'b0;
      done_n  = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.speaker  = speaker;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.note_idx = note_idx;
  assign bus.cur_code = cur_code;

endmodule

// File: tb/tb_melody_seq.sv
`timescale 1ns/1ps
// tb_melody_seq: scoreboard bench; a song-timeline model fills a queue of
// expected per-cycle outputs, a monitor pops and compares on every falling edge.
module tb_melody_seq;

  localparam int unsigned AW    = 5;
  localparam int          LEN   = 32;
  localparam int          BEAT  = 400;
  localparam int          GAP   = 40;
  localparam int          SHIFT = 8;

  localparam int EV_NONE  = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_RST   = 2;
  localparam int EV_LOOP  = 3;
  localparam int EV_START = 4;
  localparam int EV_WR    = 5;

  typedef struct packed {
    logic       spk;
    logic       busy;
    logic       done;
    logic [4:0] idx;
    logic [4:0] code;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  melody_if #(.ADDR_W(AW)) bus ();

  melody_seq #(
    .ADDR_W(AW), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .DIV_SHIFT(SHIFT), .CNT_W(19)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  rec_t       exp_q [$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [4:0] mdl_code  [LEN];
  int         mdl_beats [LEN];
  int         g_r, g_lim;
  logic [4:0] g_idx = '0;
  logic [4:0] g_code = '0;
  logic [4:0] w_code;
  int         w_beats;

  int per_tab [3][7] = '{
    '{95547, 85135, 75838, 71582, 63776, 56818, 50618},
    '{47778, 42564, 37922, 35794, 31888, 28409, 25310},
    '{23889, 21286, 18961, 16892, 15944, 14205, 12655}};

  // Half tone period in cycles for a note code; 0 = silence.
  function automatic int half_of(input logic [4:0] c);
    int ci, oct, nt;
    ci  = int'(c);
    oct = ci / 10;
    nt  = ci % 10;
    if (oct > 2 || nt < 1 || nt > 7) return 0;
    return (per_tab[oct][nt-1] >> SHIFT) / 2;
  endfunction

  // Monitor: one comparison per cycle whenever an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e, g;
      e = exp_q.pop_front();
      g.spk = bus.speaker; g.busy = bus.busy; g.done = bus.done;
      g.idx = bus.note_idx; g.code = bus.cur_code;
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got spk=%b busy=%b done=%b idx=%0d code=%0d, required spk=%b busy=%b done=%b idx=%0d code=%0d",
                 $time, g.spk, g.busy, g.done, g.idx, g.code, e.spk, e.busy, e.done, e.idx, e.code);
      end
    end
  end

  task automatic push_rec(input bit spk, input bit bsy, input bit dn, input int idx, input logic [4:0] code);
    rec_t r;
    if (g_r < g_lim) begin
      r.spk = spk; r.busy = bsy; r.done = dn; r.idx = 5'(idx); r.code = code;
      exp_q.push_back(r);
      g_idx  = 5'(idx);
      g_code = code;
    end
    g_r++;
  endtask

  // Expected timeline of one playback: LOAD, note body, gap, next entry ...
  task automatic gen_play(input bit lp, input int lp_off);
    int idx, n, h;
    logic [4:0] code;
    bit run;
    idx = 0; code = g_code; run = 1'b1;
    while (run && g_r < g_lim) begin
      push_rec(1'b0, 1'b1, 1'b0, idx, code);
      if (mdl_beats[idx] == 0) begin
        if (lp && (g_r - 1) < lp_off && idx != 0) idx = 0;
        else run = 1'b0;
      end else begin
        code = mdl_code[idx];
        h    = half_of(code);
        n    = mdl_beats[idx] * BEAT - GAP;
        for (int k = 0; k < n; k++) push_rec(h != 0 && ((k / h) % 2) == 1, 1'b1, 1'b0, idx, code);
        for (int k = 0; k < GAP; k++) push_rec(1'b0, 1'b1, 1'b0, idx, code);
        if (idx == LEN - 1) begin
          if (lp && (g_r - 1) < lp_off) idx = 0;
          else run = 1'b0;
        end else begin
          idx++;
        end
      end
    end
    if (!run) begin
      push_rec(1'b0, 1'b0, 1'b1, idx, code);
      push_rec(1'b0, 1'b0, 1'b0, idx, code);
    end
  endtask

  task automatic wr(input int a, input logic [4:0] c, input int b);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_code = c; bus.wr_beats = 4'(b);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    mdl_code[a] = c; mdl_beats[a] = b;
  endtask

  task automatic do_event(input int k, input int a, inout int cur);
    if (k == EV_NONE) return;
    repeat (a - cur) @(posedge clk);
    #1;
    if (k == EV_LOOP) begin
      bus.loop_en = 1'b0;
      cur = a;
    end else begin
      case (k)
        EV_STOP:  bus.stop = 1'b1;
        EV_RST:   rst = 1'b1;
        EV_START: bus.start = 1'b1;
        EV_WR: begin
          bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_code = w_code; bus.wr_beats = 4'(w_beats);
          mdl_code[0] = w_code; mdl_beats[0] = w_beats;
        end
        default: ;
      endcase
      @(posedge clk); #1;
      bus.stop = 1'b0; rst = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
      cur = a + 1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = exp_q.size() + 20;
    while (exp_q.size() > 0 && guard > 0) begin
      @(posedge clk);
      guard--;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected cycles never observed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // One start pulse plus up to two timed events (record index after start edge).
  task automatic run_phase(input bit lp, input int k0, input int a0, input int k1, input int a1);
    int cut, cut_k, loff, cur;
    cut = -1; cut_k = EV_NONE; loff = 1 << 30; cur = 0;
    if (k0 == EV_STOP || k0 == EV_RST) begin cut = a0; cut_k = k0; end
    else if (k1 == EV_STOP || k1 == EV_RST) begin cut = a1; cut_k = k1; end
    if (k0 == EV_LOOP) loff = a0;
    if (k1 == EV_LOOP) loff = a1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.loop_en = lp;
    @(posedge clk); #1;
    bus.start = 1'b0;
    g_r = 0;
    g_lim = (cut >= 0) ? cut + 1 : (1 << 30);
    gen_play(lp, loff);
    g_lim = 1 << 30;
    if (cut_k == EV_STOP) begin
      push_rec(1'b0, 1'b0, 1'b0, int'(g_idx), g_code);
      push_rec(1'b0, 1'b0, 1'b0, int'(g_idx), g_code);
    end else if (cut_k == EV_RST) begin
      push_rec(1'b0, 1'b0, 1'b0, 0, 5'd0);
      push_rec(1'b0, 1'b0, 1'b0, 0, 5'd0);
    end
    do_event(k0, a0, cur);
    do_event(k1, a1, cur);
    drain();
    bus.loop_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.wr_en = 1'b0;
    bus.wr_addr = '0; bus.wr_code = '0; bus.wr_beats = '0;
    for (int i = 0; i < LEN; i++) begin mdl_code[i] = '0; mdl_beats[i] = 0; end
    w_code = '0; w_beats = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    g_r = 0; g_lim = 1 << 30;
    push_rec(1'b0, 1'b0, 1'b0, 0, 5'd0);
    push_rec(1'b0, 1'b0, 1'b0, 0, 5'd0);
    drain();

    // Single beat of code 1 then end marker.
    wr(0, 5'd1, 1); wr(1, 5'd0, 0);
    run_phase(1'b0, EV_NONE, 0, EV_NONE, 0);

    // Three entries incl. a rest; a start while busy is ignored.
    wr(0, 5'd21, 2); wr(1, 5'd0, 1); wr(2, 5'd13, 1); wr(3, 5'd0, 0);
    run_phase(1'b0, EV_START, 300, EV_NONE, 0);

    // Looping 2-note song; loop_en dropped during the second pass.
    wr(0, 5'd11, 1); wr(1, 5'd17, 1); wr(2, 5'd0, 0);
    run_phase(1'b1, EV_LOOP, 1000, EV_NONE, 0);

    // Stop mid-note, then start+stop together while idle.
    wr(0, 5'd3, 2); wr(1, 5'd0, 0);
    run_phase(1'b0, EV_STOP, 200, EV_NONE, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    g_r = 0; g_lim = 1 << 30;
    for (int i = 0; i < 3; i++) push_rec(1'b0, 1'b0, 1'b0, int'(g_idx), g_code);
    drain();

    // Looping empty song must still end.
    wr(0, 5'd0, 0);
    run_phase(1'b1, EV_NONE, 0, EV_NONE, 0);

    // Full RAM without a marker; entry 5 holds undefined code 9.
    for (int i = 0; i < LEN; i++) wr(i, (i == 5) ? 5'd9 : 5'($urandom_range(0, 27)), 1);
    run_phase(1'b0, EV_NONE, 0, EV_NONE, 0);

    // Random short songs.
    for (int s = 0; s < 3; s++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wr(i, 5'($urandom_range(0, 27)), $urandom_range(1, 2));
      wr(n, 5'($urandom_range(0, 27)), 0);
      run_phase(1'b0, EV_NONE, 0, EV_NONE, 0);
    end

    // Rewrite the playing entry, reset mid-note, then replay the new entry.
    wr(0, 5'd5, 1); wr(1, 5'd0, 0);
    w_code = 5'd22; w_beats = 1;
    run_phase(1'b0, EV_WR, 100, EV_RST, 200);
    run_phase(1'b0, EV_NONE, 0, EV_NONE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
